// File: rtl/ramio_dma_master.sv
// Block-copy initiator for the RAMIO client port: moves 32-bit words between RAM
// and a valid/ready stream, one full-word access at a time.
module ramio_dma_master #(
    parameter int          LEN_WIDTH = 16,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 done,
    output logic                 err,
    output logic                 active,
    output logic                 ram_enable,
    output logic [1:0]           ram_write_type,
    output logic [2:0]           ram_read_type,
    output logic [31:0]          ram_address,
    output logic [31:0]          ram_data_in,
    input  logic [31:0]          ram_data_out,
    input  logic                 ram_data_out_ready,
    input  logic                 ram_busy
);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, PUSH, FIN
    } state_e;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [LEN_WIDTH-1:0] remain_q, remain_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic                 up_q;
    logic [32:0]          last_byte;
    logic                 range_bad;
    logic                 last_word;

    // Last byte touched, computed with a carry bit so wrap past 4 GiB is caught.
    always_comb begin
        last_byte = {1'b0, cmd_addr[31:2], 2'b00}
                  + {{(31 - LEN_WIDTH){1'b0}}, cmd_len, 2'b00} - 33'd1;
        range_bad = last_byte[32] || (last_byte[31:0] >= MMIO_BASE);
        last_word = (remain_q == LEN_ONE);
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        remain_d = remain_q;
        write_d  = write_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d   = {cmd_addr[31:2], 2'b00};
                    remain_d = cmd_len;
                    write_d  = cmd_write;
                    err_d    = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = FIN;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = cmd_write ? FETCH : ISSUE_RD;
                    end
                end
            end
            FETCH: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = ISSUE_WR;
                end
            end
            ISSUE_WR: if (!ram_busy) state_d = WAIT_WR;
            WAIT_WR: begin
                if (!ram_busy) begin
                    addr_d   = addr_q + 32'd4;
                    remain_d = remain_q - LEN_ONE;
                    state_d  = last_word ? FIN : FETCH;
                end
            end
            ISSUE_RD: if (!ram_busy) state_d = WAIT_RD;
            WAIT_RD: begin
                if (ram_data_out_ready) begin
                    data_d  = ram_data_out;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    addr_d   = addr_q + 32'd4;
                    remain_d = remain_q - LEN_ONE;
                    state_d  = last_word ? FIN : ISSUE_RD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            remain_q <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            write_q  <= write_d;
            err_q    <= err_d;
            up_q     <= 1'b1;
        end
    end

    // The request rises in the issue cycle once RAMIO is free and holds through completion,
    // which leaves exactly one idle cycle between back-to-back words.
    always_comb begin
        cmd_ready      = up_q && (state_q == IDLE);
        in_ready       = (state_q == FETCH);
        out_valid      = (state_q == PUSH);
        out_data       = data_q;
        done           = (state_q == FIN);
        err            = (state_q == FIN) && err_q;
        active         = (state_q != IDLE);
        ram_enable     = (((state_q == ISSUE_WR) || (state_q == ISSUE_RD)) && !ram_busy)
                       || (state_q == WAIT_WR) || (state_q == WAIT_RD);
        ram_write_type = (ram_enable && write_q)  ? 2'b11  : 2'b00;
        ram_read_type  = (ram_enable && !write_q) ? 3'b111 : 3'b000;
        ram_address    = addr_q;
        ram_data_in    = data_q;
    end

endmodule

// File: tb/tb_ramio_dma_master.sv
// Bench for ramio_dma_master: behavioural RAMIO with a one-line cache tag and write-back
// busy, a queue of expected stream beats and done/err results, and a monitor that checks them.
module tb_ramio_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_data;
    logic        done, err, active;
    logic        ram_enable;
    logic [1:0]  ram_write_type;
    logic [2:0]  ram_read_type;
    logic [31:0] ram_address, ram_data_in, ram_data_out;
    logic        ram_data_out_ready, ram_busy;

    always #5 clk = ~clk;

    ramio_dma_master #(.LEN_WIDTH(16), .MMIO_BASE(32'hFFFF_FFF0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .err(err), .active(active),
        .ram_enable(ram_enable), .ram_write_type(ram_write_type), .ram_read_type(ram_read_type),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_data_out_ready(ram_data_out_ready), .ram_busy(ram_busy)
    );

    // ---------------- RAMIO model ----------------
    logic [31:0] mem [0:255];
    logic [25:0] m_tag;
    logic        m_pending, m_wr;
    logic [2:0]  m_cnt, m_wb;
    logic [31:0] m_addr, m_wdata;
    logic        m_wr_commit;

    assign ram_busy           = (m_cnt != 3'd0) || (m_wb != 3'd0);
    assign ram_data_out_ready = m_pending && !m_wr && (m_cnt == 3'd0);
    assign ram_data_out       = mem[m_addr[9:2]];
    assign m_wr_commit        = rst_n && m_pending && m_wr && !ram_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tag <= '0; m_pending <= 1'b0; m_wr <= 1'b0;
            m_cnt <= '0; m_wb <= '0; m_addr <= '0; m_wdata <= '0;
        end else begin
            if (m_wb != 3'd0) m_wb <= m_wb - 3'd1;
            if (!m_pending) begin
                if (ram_enable) begin
                    m_pending <= 1'b1;
                    m_addr    <= ram_address;
                    m_wdata   <= ram_data_in;
                    m_wr      <= (ram_write_type == 2'b11);
                    if (ram_address[31:6] != m_tag) begin
                        m_tag <= ram_address[31:6];
                        m_cnt <= 3'd3;
                    end
                end
            end else if (m_cnt != 3'd0) begin
                m_cnt <= m_cnt - 3'd1;
            end else if (m_wr ? !ram_busy : 1'b1) begin
                m_pending <= 1'b0;
                if (m_wr) m_wb <= 3'd2;
            end
        end
    end

    always @(posedge clk) if (m_wr_commit) mem[m_addr[9:2]] <= m_wdata;

    // ---------------- scoreboard ----------------
    int          n_vec = 0, n_mis = 0, done_cnt = 0;
    logic [31:0] exp_q[$];
    logic        done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    logic        prev_stall = 1'b0, prev_cmpl = 1'b0, en_seen = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0; prev_cmpl = 1'b0; en_seen = 1'b0;
        end else begin
            if (prev_stall) check("out_data_held", out_data, prev_data);
            if (out_valid && !out_ready) check("no_issue_during_push", {31'd0, ram_enable}, 32'd0);
            if (prev_cmpl) check("enable_gap", {31'd0, ram_enable}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL out_beat_unexpected: got %h, expected none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (ram_enable) en_seen = 1'b1;
            prev_cmpl = ram_enable && m_pending && (m_wr ? !ram_busy : ram_data_out_ready);
            if (prev_cmpl) begin
                check("req_addr_held", ram_address, m_addr);
                if (m_wr) check("req_data_held", ram_data_in, m_wdata);
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL done_unexpected: got done=1, expected no done");
                end else begin
                    logic want_err;
                    want_err = done_q.pop_front();
                    check("done_err", {31'd0, err}, {31'd0, want_err});
                    if (want_err) check("reject_no_ram_access", {31'd0, en_seen}, 32'd0);
                end
                en_seen = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                            input logic want_err);
        bit ok = 1'b0;
        done_q.push_back(want_err);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_mis++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_mis++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > start) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_mis++;
            $display("FAIL done_timeout: got no done, expected done");
        end
        #1;
        check("beats_drained", exp_q.size(), 32'd0);
    endtask

    task automatic read_cmd(input logic [31:0] addr, input logic [15:0] len);
        int s;
        s = done_cnt;
        send_cmd(1'b0, addr, len, 1'b0);
        wait_done(s);
    endtask

    initial begin
        int s;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'hD5B8_A9C4;

        // reset state
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_enable", {31'd0, ram_enable}, 32'd0);
        check("rst_done_active", {30'd0, done, active}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // single-word read
        exp_q.push_back(32'hD5B8_A9C4);
        s = done_cnt;
        send_cmd(1'b0, 32'd16, 16'd1, 1'b0);
        check("active_after_accept", {31'd0, active}, 32'd1);
        wait_done(s);
        @(posedge clk); #1;
        check("idle_after_done", {31'd0, active}, 32'd0);

        // write two words, read them back (low address bits ignored)
        s = done_cnt;
        send_cmd(1'b1, 32'd22, 16'd2, 1'b0);
        feed_word(32'hABCD_1234);
        feed_word(32'h5555_AAAA);
        wait_done(s);
        exp_q.push_back(32'hABCD_1234);
        exp_q.push_back(32'h5555_AAAA);
        read_cmd(32'd20, 16'd2);

        // backpressure: five stalled cycles per beat
        out_ready = 1'b0;
        for (int i = 8; i < 12; i++) exp_q.push_back(32'hA000_0000 | i);
        s = done_cnt;
        send_cmd(1'b0, 32'd32, 16'd4, 1'b0);
        for (int b = 0; b < 4; b++) begin
            bit ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (out_valid) ok = 1'b1;
            end
            if (!ok) begin
                n_vec++; n_mis++;
                $display("FAIL out_valid_timeout: got out_valid=0, expected 1");
            end
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        wait_done(s);

        // cache-miss eviction then read of the evicted line
        s = done_cnt;
        send_cmd(1'b1, 32'd80, 16'd1, 1'b0);
        feed_word(32'h0000_00AB);
        wait_done(s);
        exp_q.push_back(32'hD5B8_A9C4);
        read_cmd(32'd16, 16'd1);
        exp_q.push_back(32'h0000_00AB);
        read_cmd(32'd80, 16'd1);

        // range boundaries and zero length
        exp_q.push_back(32'hA000_00FB);
        read_cmd(32'hFFFF_FFEC, 16'd1);
        s = done_cnt;
        send_cmd(1'b0, 32'hFFFF_FFF8, 16'd1, 1'b1);
        wait_done(s);
        s = done_cnt;
        send_cmd(1'b1, 32'hFFFF_FFE0, 16'd5, 1'b1);
        wait_done(s);
        s = done_cnt;
        send_cmd(1'b1, 32'd0, 16'd0, 1'b0);
        check("len0_done_next_cycle", {31'd0, done}, 32'd1);
        check("len0_no_err", {31'd0, err}, 32'd0);
        wait_done(s);

        // reset during a read miss
        send_cmd(1'b0, 32'd128, 16'd4, 1'b0);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (ram_enable && m_pending && !ram_data_out_ready) ok = 1'b1;
            end
            if (!ok) begin
                n_vec++; n_mis++;
                $display("FAIL wait_rd_timeout: got no pending read, expected one");
            end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        done_q.delete();
        check("midrst_enable_types", {26'd0, ram_enable, ram_write_type, ram_read_type}, 32'd0);
        check("midrst_handshakes", {28'd0, cmd_ready, in_ready, out_valid, done}, 32'd0);
        check("midrst_err_active", {30'd0, err, active}, 32'd0);
        check("midrst_address", ram_address, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        exp_q.push_back(32'hD5B8_A9C4);
        read_cmd(32'd16, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
